// File: rtl/ram_loader_pkg.sv
// ram_loader shared types and defaults.
// States of the loader FSM and default geometry.
package ram_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    FLUSH,
    FINISH
  } ldr_state_t;

  localparam int         DEF_ADDR_W = 14;
  localparam int         DEF_DEPTH  = 2**DEF_ADDR_W;
  localparam logic [7:0] DEF_FILL   = 8'hFF;

endpackage

// File: rtl/ram_loader_if.sv
// Download stream and RAM write port bundle.
// master = loader side, slave = frontend/RAM side.
interface ram_loader_if #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 8,
  parameter int DL_ADDR_W = 25
);

  logic                 dl_active;
  logic                 dl_wr;
  logic [DL_ADDR_W-1:0] dl_addr;
  logic [DATA_W-1:0]    dl_data;
  logic                 dl_wait;

  logic                 ram_ce;
  logic                 ram_we;
  logic [ADDR_W-1:0]    ram_addr;
  logic [DATA_W-1:0]    ram_data;

  modport master (
    input  dl_active, dl_wr,
    input  dl_addr, dl_data,
    output dl_wait,
    output ram_ce, ram_we,
    output ram_addr, ram_data
  );

  modport slave (
    output dl_active, dl_wr,
    output dl_addr, dl_data,
    input  dl_wait,
    input  ram_ce, ram_we,
    input  ram_addr, ram_data
  );

endinterface

// File: rtl/ram_loader_wr_stage.sv
// Registered RAM write stage.
// Muxes clear/hold/stream sources into one write port.
module ram_wr_stage #(
  parameter int                ADDR_W     = 14,
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] FILL_VALUE = '1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic              hold_en,
  input  logic [ADDR_W-1:0] hold_addr,
  input  logic [DATA_W-1:0] hold_data,
  input  logic              str_en,
  input  logic [ADDR_W-1:0] str_addr,
  input  logic [DATA_W-1:0] str_data,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data
);

  logic              we_d, we_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [DATA_W-1:0] data_d, data_q;

  // Select the single active write source; idle drives zeros.
  always_comb begin
    we_d   = 1'b0;
    addr_d = '0;
    data_d = '0;
    unique case (1'b1)
      clr_en: begin
        we_d   = 1'b1;
        addr_d = clr_addr;
        data_d = FILL_VALUE;
      end
      hold_en: begin
        we_d   = 1'b1;
        addr_d = hold_addr;
        data_d = hold_data;
      end
      str_en: begin
        we_d   = 1'b1;
        addr_d = str_addr;
        data_d = str_data;
      end
      default: ;
    endcase
  end

  // Output register; reset cancels any write in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign ram_ce   = we_q;
  assign ram_we   = we_q;
  assign ram_addr = addr_q;
  assign ram_data = data_q;

endmodule

// File: rtl/ram_loader.sv
// Download-to-RAM write initiator with optional pre-clear.
// FSM, clear counter, hold register and size tracking.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int                ADDR_W        = DEF_ADDR_W,
  parameter int                DATA_W        = 8,
  parameter int                DL_ADDR_W     = 25,
  parameter logic [DATA_W-1:0] FILL_VALUE    = DATA_W'(DEF_FILL),
  parameter bit                CLEAR_ON_LOAD = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_req,
  ram_loader_if.master      bus,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   size,
  output logic              overflow
);

  ldr_state_t        state_d, state_q;
  logic [ADDR_W-1:0] clr_cnt_d, clr_cnt_q;
  logic              from_dl_d, from_dl_q;
  logic              act_q;
  logic              hold_v_d, hold_v_q;
  logic [ADDR_W-1:0] hold_addr_d, hold_addr_q;
  logic [DATA_W-1:0] hold_data_d, hold_data_q;
  logic [ADDR_W:0]   size_d, size_q;
  logic              ovf_d, ovf_q;
  logic              busy_d, busy_q;
  logic              done_d, done_q;
  logic              wait_d, wait_q;

  logic              clr_en, hold_en, str_en;
  logic              rise, in_range;
  logic [ADDR_W-1:0] dl_lo;
  logic [ADDR_W:0]   dl_end, hold_end;

  assign rise     = bus.dl_active & ~act_q;
  assign in_range = bus.dl_addr[DL_ADDR_W-1:ADDR_W] == '0;
  assign dl_lo    = bus.dl_addr[ADDR_W-1:0];
  assign dl_end   = {1'b0, dl_lo} + 1'b1;
  assign hold_end = {1'b0, hold_addr_q} + 1'b1;

  // Next state, hold register, size/overflow, write requests.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    from_dl_d   = from_dl_q;
    hold_v_d    = hold_v_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    size_d      = size_q;
    ovf_d       = ovf_q;
    clr_en      = 1'b0;
    hold_en     = 1'b0;
    str_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise || clear_req) begin
          clr_cnt_d = '0;
          size_d    = '0;
          ovf_d     = 1'b0;
          hold_v_d  = 1'b0;
          from_dl_d = rise;
          if (rise && !CLEAR_ON_LOAD)
            state_d = LOAD;
          else
            state_d = CLEAR;
        end
      end
      CLEAR: begin
        clr_en    = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (!bus.dl_active)
          from_dl_d = 1'b0;
        if (from_dl_q && bus.dl_active
            && bus.dl_wr) begin
          if (hold_v_q || !in_range) begin
            ovf_d = 1'b1;
          end else begin
            hold_v_d    = 1'b1;
            hold_addr_d = dl_lo;
            hold_data_d = bus.dl_data;
          end
        end
        if (&clr_cnt_q) begin
          if (from_dl_q && bus.dl_active)
            state_d = LOAD;
          else
            state_d = FINISH;
        end
      end
      LOAD: begin
        if (hold_v_q) begin
          hold_en  = 1'b1;
          hold_v_d = 1'b0;
          if (hold_end > size_q)
            size_d = hold_end;
        end
        if (bus.dl_wr) begin
          if (!in_range) begin
            ovf_d = 1'b1;
          end else if (hold_v_q) begin
            hold_v_d    = 1'b1;
            hold_addr_d = dl_lo;
            hold_data_d = bus.dl_data;
          end else begin
            str_en = 1'b1;
            if (dl_end > size_q)
              size_d = dl_end;
          end
        end
        if (!bus.dl_active)
          state_d = FLUSH;
      end
      FLUSH: begin
        if (hold_v_q) begin
          hold_en = 1'b1;
          if (hold_end > size_q)
            size_d = hold_end;
        end
        hold_v_d = 1'b0;
        state_d  = FINISH;
      end
      FINISH: begin
        hold_v_d  = 1'b0;
        from_dl_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE)
           || (state_q != IDLE);
    done_d = state_q == FINISH;
    wait_d = (state_d == CLEAR)
           || ((state_d == LOAD) && hold_v_d);
  end

  // State and status registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      clr_cnt_q   <= '0;
      from_dl_q   <= 1'b0;
      act_q       <= 1'b0;
      hold_v_q    <= 1'b0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      size_q      <= '0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wait_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      from_dl_q   <= from_dl_d;
      act_q       <= bus.dl_active;
      hold_v_q    <= hold_v_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      size_q      <= size_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wait_q      <= wait_d;
    end
  end

  ram_wr_stage #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .FILL_VALUE (FILL_VALUE)
  ) u_wr (
    .clock     (clock),
    .reset     (reset),
    .clr_en    (clr_en),
    .clr_addr  (clr_cnt_q),
    .hold_en   (hold_en),
    .hold_addr (hold_addr_q),
    .hold_data (hold_data_q),
    .str_en    (str_en),
    .str_addr  (dl_lo),
    .str_data  (bus.dl_data),
    .ram_ce    (bus.ram_ce),
    .ram_we    (bus.ram_we),
    .ram_addr  (bus.ram_addr),
    .ram_data  (bus.ram_data)
  );

  assign bus.dl_wait = wait_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign size        = size_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_ram_loader.sv
// ram_loader bench: directed sequence, random bytes,
// RAM image / write-log reference model.
module tb_ram_loader;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DLW   = 8;
  localparam int DEPTH = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          clear_req;
  logic          busy, done, overflow;
  logic [AW:0]   size;

  ram_loader_if #(
    .ADDR_W(AW), .DATA_W(DW), .DL_ADDR_W(DLW)
  ) bus ();

  ram_loader #(
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .DL_ADDR_W     (DLW),
    .FILL_VALUE    (8'hFF),
    .CLEAR_ON_LOAD (1'b1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .clear_req (clear_req),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .size      (size),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // observed RAM: write log plus the image a real RAM would hold
  int         wr_cyc[$];
  int         wr_addr[$];
  int         wr_data[$];
  int         busy_total = 0;
  int         done_total = 0;
  int         done_cyc   = 0;
  int         ce_bad     = 0;
  logic [7:0] img [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++)
      img[i] = 8'($urandom_range(0, 254));
    forever begin
      @(negedge clock);
      if (bus.ram_ce === 1'b1 && bus.ram_we === 1'b1) begin
        wr_cyc.push_back(cyc);
        wr_addr.push_back(int'(bus.ram_addr));
        wr_data.push_back(int'(bus.ram_data));
        img[bus.ram_addr] = bus.ram_data;
      end
      if (bus.ram_ce !== bus.ram_we) ce_bad++;
      if (busy === 1'b1) busy_total++;
      if (done === 1'b1) begin
        done_total++;
        done_cyc = cyc;
      end
    end
  end

  // reference model
  int         ex_cyc[$];
  int         ex_addr[$];
  int         ex_data[$];
  logic [7:0] exp_img [DEPTH];
  int         exp_size;
  bit         exp_ovf;

  int checks   = 0;
  int failures = 0;

  task automatic chk(string tag,
                     logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) exp_img[i] = 8'hFF;
    exp_size = 0;
    exp_ovf  = 1'b0;
    ex_cyc.delete();
    ex_addr.delete();
    ex_data.delete();
  endtask

  task automatic send(int a, int d, bit last);
    bus.dl_wr   = 1'b1;
    bus.dl_addr = DLW'(a);
    bus.dl_data = DW'(d);
    if (last) bus.dl_active = 1'b0;
    if (a < DEPTH) begin
      ex_cyc.push_back(cyc + 1);
      ex_addr.push_back(a);
      ex_data.push_back(d & 8'hFF);
      exp_img[a] = 8'(d);
      if (a + 1 > exp_size) exp_size = a + 1;
    end else begin
      exp_ovf = 1'b1;
    end
    tick();
    bus.dl_wr = 1'b0;
  endtask

  task automatic wait_wait(logic v, int budget,
                           string tag);
    int n = 0;
    while (bus.dl_wait !== v && n < budget) begin
      tick();
      n++;
    end
    chk(tag, bus.dl_wait, v);
  endtask

  task automatic wait_done(int d0, string tag);
    int n = 0;
    while (done_total == d0 && n < 80) begin
      tick();
      n++;
    end
    tick(3);
    chk(tag, done_total - d0, 1);
  endtask

  task automatic chk_clear(int base, string tag);
    int bad = 0;
    if (wr_addr.size() < base + DEPTH) bad = DEPTH;
    else for (int i = 0; i < DEPTH; i++) begin
      if (wr_addr[base+i] != i) bad++;
      if (wr_data[base+i] != 8'hFF) bad++;
      if (i > 0 && wr_cyc[base+i] != wr_cyc[base+i-1] + 1)
        bad++;
    end
    chk(tag, bad, 0);
  endtask

  task automatic chk_stream(int base, string tag);
    int bad = 0;
    int n = ex_addr.size();
    chk({tag, "_cnt"}, wr_addr.size() - base, n);
    for (int i = 0; i < n; i++) begin
      if (base + i >= wr_addr.size()) bad++;
      else begin
        if (wr_cyc[base+i]  != ex_cyc[i])  bad++;
        if (wr_addr[base+i] != ex_addr[i]) bad++;
        if (wr_data[base+i] != ex_data[i]) bad++;
      end
    end
    chk(tag, bad, 0);
  endtask

  task automatic chk_img(string tag);
    int bad = 0;
    for (int i = 0; i < DEPTH; i++)
      if (img[i] !== exp_img[i]) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_size"}, size, 0);
    chk({tag, "_ovf"},  overflow, 0);
    chk({tag, "_wait"}, bus.dl_wait, 0);
    chk({tag, "_ram"},
        {bus.ram_ce, bus.ram_we,
         bus.ram_addr, bus.ram_data}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, d0, b0, n, found, a;
    reset         = 1'b1;
    clear_req     = 1'b0;
    bus.dl_active = 1'b0;
    bus.dl_wr     = 1'b0;
    bus.dl_addr   = '0;
    bus.dl_data   = '0;
    tick(3);
    chk_zero("rst");
    reset = 1'b0;
    tick(2);

    // dl_wr in IDLE is ignored
    base = wr_addr.size();
    bus.dl_wr   = 1'b1;
    bus.dl_addr = 8'd3;
    bus.dl_data = 8'h5A;
    tick();
    bus.dl_wr = 1'b0;
    tick(3);
    chk("idle_wr_none", wr_addr.size() - base, 0);
    chk("idle_wr_ovf", overflow, 0);

    // stand-alone clear
    model_clear();
    base = wr_addr.size();
    d0 = done_total;
    b0 = busy_total;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    wait_done(d0, "clr_done");
    chk("clr_cnt", wr_addr.size() - base, DEPTH);
    chk_clear(base, "clr_seq");
    chk("clr_busy", busy_total - b0, 18);
    chk("clr_done_after", done_cyc > wr_cyc[$], 1);
    chk_img("clr_img");

    // download with pre-clear, random tail
    model_clear();
    base = wr_addr.size();
    d0 = done_total;
    bus.dl_active = 1'b1;
    wait_wait(1'b1, 5, "dl_wait_hi");
    wait_wait(1'b0, 40, "dl_wait_lo");
    send(0, 8'h11, 1'b0);
    send(1, 8'h22, 1'b0);
    send(2, 8'h33, 1'b0);
    n = $urandom_range(2, 6);
    for (int i = 0; i < n; i++)
      send($urandom_range(0, DEPTH - 1),
           $urandom_range(0, 255), 1'b0);
    tick();
    bus.dl_active = 1'b0;
    wait_done(d0, "dl_done");
    chk_clear(base, "dl_clear");
    chk_stream(base + DEPTH, "dl_stream");
    chk("dl_size", size, exp_size);
    chk("dl_ovf", overflow, exp_ovf);
    chk_img("dl_img");

    // strobes while clearing: first held, second dropped
    model_clear();
    base = wr_addr.size();
    d0 = done_total;
    bus.dl_active = 1'b1;
    wait_wait(1'b1, 5, "hold_wait_hi");
    tick(2);
    bus.dl_wr   = 1'b1;
    bus.dl_addr = 8'd5;
    bus.dl_data = 8'hA5;
    tick();
    bus.dl_wr = 1'b0;
    ex_cyc.push_back(0);
    ex_addr.push_back(5);
    ex_data.push_back(8'hA5);
    exp_img[5] = 8'hA5;
    exp_size = 6;
    tick();
    chk("hold_first_ovf", overflow, 0);
    bus.dl_wr   = 1'b1;
    bus.dl_addr = 8'd9;
    bus.dl_data = 8'($urandom_range(0, 254));
    tick();
    bus.dl_wr = 1'b0;
    exp_ovf = 1'b1;
    tick();
    chk("hold_second_ovf", overflow, 1);
    wait_wait(1'b0, 40, "hold_wait_lo");
    if (wr_cyc.size() >= base + DEPTH)
      ex_cyc[0] = wr_cyc[base + DEPTH - 1] + 1;
    send($urandom_range(10, 15),
         $urandom_range(0, 255), 1'b1);
    wait_done(d0, "hold_done");
    chk_clear(base, "hold_clear");
    chk_stream(base + DEPTH, "hold_stream");
    chk("hold_size", size, exp_size);
    chk("hold_ovf", overflow, 1);
    chk_img("hold_img");

    // out of range, full size, write on dl_active fall
    model_clear();
    base = wr_addr.size();
    d0 = done_total;
    bus.dl_active = 1'b1;
    wait_wait(1'b1, 5, "oor_wait_hi");
    wait_wait(1'b0, 40, "oor_wait_lo");
    send(16, $urandom_range(0, 255), 1'b0);
    send(31, $urandom_range(0, 255), 1'b0);
    send($urandom_range(17, 255),
         $urandom_range(0, 255), 1'b0);
    tick(2);
    chk("oor_size", size, 0);
    chk("oor_ovf", overflow, 1);
    send(15, $urandom_range(0, 255), 1'b0);
    tick();
    chk("full_size", size, 16);
    send(7, $urandom_range(0, 255), 1'b1);
    wait_done(d0, "edge_done");
    chk_stream(base + DEPTH, "edge_stream");
    chk("edge_done_after", done_cyc > wr_cyc[$], 1);
    chk("edge_size", size, exp_size);
    chk("edge_ovf", overflow, 1);
    chk_img("edge_img");

    // reset in the middle of a clear
    base = wr_addr.size();
    d0 = done_total;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      if (bus.ram_ce === 1'b1 && bus.ram_addr == 4'd5)
        found = 1;
      else
        tick();
    end
    chk("mid_found", found, 1);
    reset = 1'b1;
    tick();
    chk_zero("mid_rst");
    tick();
    reset = 1'b0;
    tick(10);
    chk("mid_wr_cnt", wr_addr.size() - base, 6);
    a = (wr_addr.size() > 0) ? wr_addr[$] : -1;
    chk("mid_last_addr", a, 5);
    chk("mid_no_done", done_total - d0, 0);
    model_clear();
    base = wr_addr.size();
    d0 = done_total;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    wait_done(d0, "restart_done");
    chk_clear(base, "restart_seq");
    chk_img("restart_img");

    chk("ce_we_pair", ce_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
